// File: rtl/dq_pkg.sv
// Shared types and pointer helper for the data-queue clear issuer.
package dq_pkg;

  localparam int DQ_DEPTH_DEF = 30;

  typedef logic [$clog2(DQ_DEPTH_DEF)-1:0] dq_idx_t;

  // Circular-pointer advance; valid while p < depth and n <= depth.
  function automatic int wrap_add(input int p, input int n, input int depth);
    return (p + n >= depth) ? p + n - depth : p + n;
  endfunction

endpackage

// File: rtl/req_compact.sv
// Valid-compaction network: packs valid indices toward slot 0 in port order.
module req_compact
  import dq_pkg::*;
#(
  parameter int IN_NUM = 6,
  parameter int IW     = $clog2(DQ_DEPTH_DEF),
  parameter int NW     = $clog2(IN_NUM + 1)
) (
  input  logic [IN_NUM-1:0]         vld_i,
  input  logic [IN_NUM-1:0][IW-1:0] idx_i,
  output logic [IN_NUM-1:0][IW-1:0] idx_o,
  output logic [NW-1:0]             num_o
);

  logic [IN_NUM-1:0][NW-1:0] pos;
  logic [NW-1:0]             cnt;

  always_comb begin
    cnt = '0;
    pos = '0;
    for (int i = 0; i < IN_NUM; i++) begin
      pos[i] = cnt;
      cnt    = cnt + NW'(vld_i[i]);
    end
    num_o = cnt;
    // Slot k takes the unique valid port with exactly k valid ports below it.
    idx_o = '0;
    for (int k = 0; k < IN_NUM; k++)
      for (int i = 0; i < IN_NUM; i++)
        if (vld_i[i] && pos[i] == NW'(k)) idx_o[k] = idx_i[i];
  end

endmodule

// File: rtl/dq_clear_issuer.sv
// Buffers completion indices in a circular FIFO and issues up to CLEARPORT_NUM clears per cycle.
// Optional duplicate filtering enabled by defining DQ_CLEAR_DUPCHK_EN.
module dq_clear_issuer
  import dq_pkg::*;
#(
  parameter int DQ_DEPTH      = DQ_DEPTH_DEF,
  parameter int IN_NUM        = 6,
  parameter int CLEARPORT_NUM = 4,
  parameter int FIFO_DEPTH    = 16,
  localparam int IW = $clog2(DQ_DEPTH),
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int CW = $clog2(FIFO_DEPTH + 1),
  localparam int NW = $clog2(IN_NUM + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_flush,
  input  logic [IN_NUM-1:0]                i_req_vld,
  input  logic [IN_NUM-1:0][IW-1:0]        i_req_dqIdx,
  output logic                             o_req_rdy,
  output logic [CLEARPORT_NUM-1:0]         o_clear_vld,
  output logic [CLEARPORT_NUM-1:0][IW-1:0] o_clear_dqIdx,
  output logic [CW-1:0]                    o_count,
  output logic                             o_dup_err
);

  logic [FIFO_DEPTH-1:0][IW-1:0] fifo_q;
  logic [PW-1:0]                 head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]                 count_q, count_d;
  logic [IN_NUM-1:0]             keep;
  logic [IN_NUM-1:0][IW-1:0]     cmp_idx;
  logic [NW-1:0]                 cmp_num;
  logic                          accept;
  int                            req_num, acc_num, iss_num;

  // Readiness counts every valid request, including ones later dropped as duplicates.
  assign req_num   = $countones(i_req_vld);
  assign o_req_rdy = req_num <= FIFO_DEPTH - int'(count_q);
  assign accept    = o_req_rdy && !i_flush;
  assign iss_num   = (int'(count_q) < CLEARPORT_NUM) ? int'(count_q) : CLEARPORT_NUM;
  assign acc_num   = accept ? int'(cmp_num) : 0;
  assign o_count   = count_q;

  req_compact #(.IN_NUM(IN_NUM), .IW(IW), .NW(NW)) u_compact (
    .vld_i (keep),
    .idx_i (i_req_dqIdx),
    .idx_o (cmp_idx),
    .num_o (cmp_num)
  );

  always_comb begin
    o_clear_vld   = '0;
    o_clear_dqIdx = '0;
    for (int k = 0; k < CLEARPORT_NUM; k++) begin
      o_clear_vld[k]   = k < iss_num;
      o_clear_dqIdx[k] = fifo_q[PW'(wrap_add(int'(head_q), k, FIFO_DEPTH))];
    end
  end

  assign head_d  = PW'(wrap_add(int'(head_q), iss_num, FIFO_DEPTH));
  assign tail_d  = PW'(wrap_add(int'(tail_q), acc_num, FIFO_DEPTH));
  assign count_d = CW'(int'(count_q) + acc_num - iss_num);

  always_ff @(posedge clk) begin
    if (!rst || i_flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (rst && accept)
      for (int j = 0; j < IN_NUM; j++)
        if (j < int'(cmp_num))
          fifo_q[PW'(wrap_add(int'(tail_q), j, FIFO_DEPTH))] <= cmp_idx[j];
  end

`ifdef DQ_CLEAR_DUPCHK_EN
  logic [DQ_DEPTH-1:0] pend_q, pend_d;
  logic [IN_NUM-1:0]   drop;
  logic                dup_q;

  always_comb begin
    drop = '0;
    for (int i = 0; i < IN_NUM; i++) begin
      if (i_req_vld[i]) begin
        if (int'(i_req_dqIdx[i]) < DQ_DEPTH && pend_q[i_req_dqIdx[i]]) drop[i] = 1'b1;
        for (int j = 0; j < i; j++)
          if (i_req_vld[j] && i_req_dqIdx[j] == i_req_dqIdx[i]) drop[i] = 1'b1;
      end
    end
  end

  assign keep = i_req_vld & ~drop;

  always_comb begin
    pend_d = pend_q;
    for (int k = 0; k < CLEARPORT_NUM; k++)
      if (k < iss_num) pend_d[o_clear_dqIdx[k]] = 1'b0;
    for (int j = 0; j < IN_NUM; j++)
      if (j < acc_num) pend_d[cmp_idx[j]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst || i_flush) pend_q <= '0;
    else                 pend_q <= pend_d;
    if (!rst) dup_q <= 1'b0;
    else      dup_q <= accept && |drop;
  end

  assign o_dup_err = dup_q;
`else
  assign keep      = i_req_vld;
  assign o_dup_err = 1'b0;
`endif

endmodule

// File: tb/tb_dq_clear_issuer.sv
// Directed self-checking bench for dq_clear_issuer (default parameters).
module tb_dq_clear_issuer;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_flush;
  logic [5:0]      i_req_vld;
  logic [5:0][4:0] i_req_dqIdx;
  logic            o_req_rdy;
  logic [3:0]      o_clear_vld;
  logic [3:0][4:0] o_clear_dqIdx;
  logic [4:0]      o_count;
  logic            o_dup_err;

  int pass  = 0;
  int total = 0;

  dq_clear_issuer dut (
    .clk           (clk),
    .rst           (rst),
    .i_flush       (i_flush),
    .i_req_vld     (i_req_vld),
    .i_req_dqIdx   (i_req_dqIdx),
    .o_req_rdy     (o_req_rdy),
    .o_clear_vld   (o_clear_vld),
    .o_clear_dqIdx (o_clear_dqIdx),
    .o_count       (o_count),
    .o_dup_err     (o_dup_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] v, input int base);
    i_req_vld = v;
    for (int i = 0; i < 6; i++) i_req_dqIdx[i] = 5'(base + i);
  endtask

  task automatic test_reset;
    rst = 1'b0; i_flush = 1'b0; drive(6'b0, 0);
    tick; tick;
    total++; if (o_count !== 5'd0) $display("FAIL reset_count: got %0d want 0", o_count); else pass++;
    total++; if (o_clear_vld !== 4'b0) $display("FAIL reset_vld: got %b want 0000", o_clear_vld); else pass++;
    total++; if (o_req_rdy !== 1'b1) $display("FAIL reset_rdy: got %b want 1", o_req_rdy); else pass++;
    total++; if (o_dup_err !== 1'b0) $display("FAIL reset_dup: got %b want 0", o_dup_err); else pass++;
    rst = 1'b1;
  endtask

  task automatic test_basic;
    i_req_vld = 6'b000101;
    i_req_dqIdx = '0;
    i_req_dqIdx[0] = 5'd3;
    i_req_dqIdx[2] = 5'd7;
    #1;
    total++; if (o_req_rdy !== 1'b1) $display("FAIL basic_rdy: got %b want 1", o_req_rdy); else pass++;
    tick;
    drive(6'b0, 0);
    #1;
    total++; if (o_clear_vld !== 4'b0011) $display("FAIL basic_vld: got %b want 0011", o_clear_vld); else pass++;
    total++; if (o_clear_dqIdx[0] !== 5'd3) $display("FAIL basic_idx0: got %0d want 3", o_clear_dqIdx[0]); else pass++;
    total++; if (o_clear_dqIdx[1] !== 5'd7) $display("FAIL basic_idx1: got %0d want 7", o_clear_dqIdx[1]); else pass++;
    total++; if (o_count !== 5'd2) $display("FAIL basic_count: got %0d want 2", o_count); else pass++;
    tick;
    total++; if (o_count !== 5'd0) $display("FAIL basic_drained: got %0d want 0", o_count); else pass++;
    total++; if (o_clear_vld !== 4'b0) $display("FAIL basic_idle_vld: got %b want 0000", o_clear_vld); else pass++;
  endtask

  // Six requests per cycle against four issues per cycle until backpressure.
  task automatic test_back_to_back;
    int   ecnt[8] = '{0, 6, 8, 10, 12, 8, 4, 0};
    int   eiss[8] = '{0, 4, 4, 4, 4, 4, 4, 0};
    logic erdy[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int   nxt = 0;
    for (int c = 0; c < 8; c++) begin
      if (c < 5) drive(6'h3f, c * 6); else drive(6'b0, 0);
      #1;
      total++; if (o_count !== 5'(ecnt[c])) $display("FAIL b2b_count c%0d: got %0d want %0d", c, o_count, ecnt[c]); else pass++;
      if (c < 5) begin
        total++; if (o_req_rdy !== erdy[c]) $display("FAIL b2b_rdy c%0d: got %b want %b", c, o_req_rdy, erdy[c]); else pass++;
      end
      total++; if (o_clear_vld !== ((eiss[c] == 4) ? 4'hf : 4'h0)) $display("FAIL b2b_vld c%0d: got %b want %0d set", c, o_clear_vld, eiss[c]); else pass++;
      for (int k = 0; k < eiss[c]; k++) begin
        total++; if (o_clear_dqIdx[k] !== 5'(nxt)) $display("FAIL b2b_order c%0d p%0d: got %0d want %0d", c, k, o_clear_dqIdx[k], nxt); else pass++;
        nxt++;
      end
      tick;
    end
  endtask

  // After reset, 14 pushes and full drain leave head=tail=14; next 4 land in slots 14,15,0,1.
  task automatic test_wrap;
    rst = 1'b0; drive(6'b0, 0); tick; rst = 1'b1;
    drive(6'h3f, 0);       tick;
    drive(6'h3f, 6);       tick;
    drive(6'b000011, 12);  tick;
    drive(6'b0, 0);        tick; tick;
    total++; if (o_count !== 5'd0) $display("FAIL wrap_pre_count: got %0d want 0", o_count); else pass++;
    drive(6'b001111, 9);
    #1;
    total++; if (o_req_rdy !== 1'b1) $display("FAIL wrap_rdy: got %b want 1", o_req_rdy); else pass++;
    tick;
    drive(6'b0, 0);
    #1;
    total++; if (o_count !== 5'd4) $display("FAIL wrap_count: got %0d want 4", o_count); else pass++;
    total++; if (o_clear_vld !== 4'hf) $display("FAIL wrap_vld: got %b want 1111", o_clear_vld); else pass++;
    for (int k = 0; k < 4; k++) begin
      total++; if (o_clear_dqIdx[k] !== 5'(9 + k)) $display("FAIL wrap_idx p%0d: got %0d want %0d", k, o_clear_dqIdx[k], 9 + k); else pass++;
    end
    tick;
    total++; if (o_count !== 5'd0) $display("FAIL wrap_post_count: got %0d want 0", o_count); else pass++;
  endtask

  task automatic test_flush;
    drive(6'h3f, 0);      tick;
    drive(6'h3f, 6);      tick;
    drive(6'b011111, 12); tick;
    drive(6'b000111, 20);
    i_flush = 1'b1;
    #1;
    total++; if (o_count !== 5'd9) $display("FAIL flush_pre_count: got %0d want 9", o_count); else pass++;
    total++; if (o_clear_vld !== 4'hf) $display("FAIL flush_cycle_vld: got %b want 1111", o_clear_vld); else pass++;
    tick;
    i_flush = 1'b0;
    drive(6'b0, 0);
    #1;
    total++; if (o_count !== 5'd0) $display("FAIL flush_count: got %0d want 0", o_count); else pass++;
    total++; if (o_clear_vld !== 4'b0) $display("FAIL flush_vld: got %b want 0000", o_clear_vld); else pass++;
    tick;
    total++; if (o_clear_vld !== 4'b0) $display("FAIL flush_dropped: got %b want 0000", o_clear_vld); else pass++;
  endtask

  task automatic test_reset_mid;
    drive(6'b011111, 0); tick;
    drive(6'b0, 0);
    #1;
    total++; if (o_count !== 5'd5) $display("FAIL rstmid_pre_count: got %0d want 5", o_count); else pass++;
    rst = 1'b0;
    tick;
    rst = 1'b1;
    total++; if (o_count !== 5'd0) $display("FAIL rstmid_count: got %0d want 0", o_count); else pass++;
    total++; if (o_clear_vld !== 4'b0) $display("FAIL rstmid_vld: got %b want 0000", o_clear_vld); else pass++;
    total++; if (o_req_rdy !== 1'b1) $display("FAIL rstmid_rdy: got %b want 1", o_req_rdy); else pass++;
    total++; if (o_dup_err !== 1'b0) $display("FAIL rstmid_dup: got %b want 0", o_dup_err); else pass++;
    drive(6'b000011, 17);
    tick;
    drive(6'b0, 0);
    #1;
    total++; if (o_clear_vld !== 4'b0011) $display("FAIL rstmid_new_vld: got %b want 0011", o_clear_vld); else pass++;
    total++; if (o_clear_dqIdx[0] !== 5'd17) $display("FAIL rstmid_new_idx0: got %0d want 17", o_clear_dqIdx[0]); else pass++;
    total++; if (o_clear_dqIdx[1] !== 5'd18) $display("FAIL rstmid_new_idx1: got %0d want 18", o_clear_dqIdx[1]); else pass++;
    total++; if (o_count !== 5'd2) $display("FAIL rstmid_new_count: got %0d want 2", o_count); else pass++;
    tick;
  endtask

  task automatic test_dup;
    drive(6'b000001, 5);
    tick;
    i_req_vld = 6'b000011;
    i_req_dqIdx = '0;
    i_req_dqIdx[0] = 5'd5;
    i_req_dqIdx[1] = 5'd5;
    #1;
    total++; if (o_count !== 5'd1) $display("FAIL dup_pre_count: got %0d want 1", o_count); else pass++;
    total++; if (o_clear_vld !== 4'b0001 || o_clear_dqIdx[0] !== 5'd5) $display("FAIL dup_first: got vld %b idx %0d want 0001/5", o_clear_vld, o_clear_dqIdx[0]); else pass++;
    tick;
    drive(6'b0, 0);
    #1;
`ifdef DQ_CLEAR_DUPCHK_EN
    total++; if (o_count !== 5'd0) $display("FAIL dup_count: got %0d want 0", o_count); else pass++;
    total++; if (o_clear_vld !== 4'b0) $display("FAIL dup_vld: got %b want 0000", o_clear_vld); else pass++;
    total++; if (o_dup_err !== 1'b1) $display("FAIL dup_err: got %b want 1", o_dup_err); else pass++;
    tick;
    total++; if (o_dup_err !== 1'b0) $display("FAIL dup_err_pulse: got %b want 0", o_dup_err); else pass++;
`else
    total++; if (o_count !== 5'd2) $display("FAIL dup_count: got %0d want 2", o_count); else pass++;
    total++; if (o_clear_vld !== 4'b0011) $display("FAIL dup_vld: got %b want 0011", o_clear_vld); else pass++;
    total++; if (o_clear_dqIdx[0] !== 5'd5 || o_clear_dqIdx[1] !== 5'd5) $display("FAIL dup_idx: got %0d,%0d want 5,5", o_clear_dqIdx[0], o_clear_dqIdx[1]); else pass++;
    total++; if (o_dup_err !== 1'b0) $display("FAIL dup_err: got %b want 0", o_dup_err); else pass++;
    tick;
    total++; if (o_count !== 5'd0) $display("FAIL dup_drained: got %0d want 0", o_count); else pass++;
`endif
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_wrap;
    test_flush;
    test_reset_mid;
    test_dup;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
